// File: rtl/washer_ctrl_multirinse.sv
// Washing-machine sequencer: fill, detergent, wash agitate, drain, then
// NUM_RINSE fill/agitate/drain rinse rounds, then spin. Supports pause
// during agitate/spin, and fill/drain watchdogs that latch a fault until reset.
module washer_ctrl_multirinse #(
    parameter int TIMER_W     = 16,
    parameter int WASH_TICKS  = 1000,
    parameter int RINSE_TICKS = 500,
    parameter int SPIN_TICKS  = 300,
    parameter int NUM_RINSE   = 2,
    parameter int FILL_LIMIT  = 4000,
    parameter int DRAIN_LIMIT = 4000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       door_close,
    input  logic       start,
    input  logic       pause,
    input  logic       filled,
    input  logic       detergent_added,
    input  logic       drained,
    output logic       door_lock,
    output logic       motor_on,
    output logic       fill_valve_on,
    output logic       drain_valve_on,
    output logic       done,
    output logic       fault,
    output logic [3:0] state_o,
    output logic [3:0] rinse_cnt
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FILL      = 4'd1,
        S_DETERGENT = 4'd2,
        S_AGITATE   = 4'd3,
        S_DRAIN     = 4'd4,
        S_SPIN      = 4'd5,
        S_PAUSED    = 4'd6,
        S_DONE      = 4'd7,
        S_FAULT     = 4'd8
    } state_t;

    // Terminal timer values: a phase of N cycles ends when the timer reads N-1.
    localparam logic [TIMER_W-1:0] WASH_LAST  = TIMER_W'(WASH_TICKS - 1);
    localparam logic [TIMER_W-1:0] RINSE_LAST = TIMER_W'(RINSE_TICKS - 1);
    localparam logic [TIMER_W-1:0] SPIN_LAST  = TIMER_W'(SPIN_TICKS - 1);
    localparam logic [TIMER_W-1:0] FILL_LAST  = TIMER_W'(FILL_LIMIT - 1);
    localparam logic [TIMER_W-1:0] DRAIN_LAST = TIMER_W'(DRAIN_LIMIT - 1);
    localparam logic [3:0]         RINSE_NUM  = 4'(NUM_RINSE);

    state_t             state;
    state_t             ret_state;    // where PAUSED resumes to
    logic [TIMER_W-1:0] timer;
    logic               phase_rinse;  // 0 = wash phase, 1 = rinse phase
    logic [TIMER_W-1:0] agit_last;

    // Saturating increment so a stuck timer can never wrap back onto a limit.
    function automatic logic [TIMER_W-1:0] tick(input logic [TIMER_W-1:0] t);
        return (t == {TIMER_W{1'b1}}) ? t : t + 1'b1;
    endfunction

    assign agit_last = phase_rinse ? RINSE_LAST : WASH_LAST;

    // Sequencer: state, phase, rinse count and the shared phase timer.
    // The timer is cleared on every entry except the return from PAUSED,
    // where it simply keeps the value it was frozen at.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ret_state   <= S_IDLE;
            timer       <= '0;
            phase_rinse <= 1'b0;
            rinse_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && door_close) begin
                        state       <= S_FILL;
                        timer       <= '0;
                        phase_rinse <= 1'b0;
                        rinse_cnt   <= '0;
                    end
                end
                S_FILL: begin
                    // A sensor arriving on the limit cycle beats the watchdog.
                    if (filled) begin
                        state <= phase_rinse ? S_AGITATE : S_DETERGENT;
                        timer <= '0;
                    end else if (timer == FILL_LAST) begin
                        state <= S_FAULT;
                        timer <= '0;
                    end else begin
                        timer <= tick(timer);
                    end
                end
                S_DETERGENT: begin
                    if (detergent_added) begin
                        state <= S_AGITATE;
                        timer <= '0;
                    end
                end
                S_AGITATE: begin
                    // Pause wins over terminal count; the timer is frozen.
                    if (pause) begin
                        ret_state <= S_AGITATE;
                        state     <= S_PAUSED;
                    end else if (timer == agit_last) begin
                        state <= S_DRAIN;
                        timer <= '0;
                    end else begin
                        timer <= tick(timer);
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        timer <= '0;
                        if (rinse_cnt < RINSE_NUM) begin
                            state       <= S_FILL;
                            phase_rinse <= 1'b1;
                            rinse_cnt   <= rinse_cnt + 1'b1;
                        end else begin
                            state <= S_SPIN;
                        end
                    end else if (timer == DRAIN_LAST) begin
                        state <= S_FAULT;
                        timer <= '0;
                    end else begin
                        timer <= tick(timer);
                    end
                end
                S_SPIN: begin
                    if (pause) begin
                        ret_state <= S_SPIN;
                        state     <= S_PAUSED;
                    end else if (timer == SPIN_LAST) begin
                        state <= S_DONE;
                        timer <= '0;
                    end else begin
                        timer <= tick(timer);
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        state <= ret_state;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    timer <= '0;
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // Moore output decode from the state register; reset forces IDLE, so
    // every output (including the door latch) drops as soon as reset rises.
    always_comb begin
        door_lock      = 1'b0;
        motor_on       = 1'b0;
        fill_valve_on  = 1'b0;
        drain_valve_on = 1'b0;
        done           = 1'b0;
        fault          = 1'b0;
        state_o        = state;
        case (state)
            S_FILL:      begin door_lock = 1'b1; fill_valve_on = 1'b1; end
            S_DETERGENT: begin door_lock = 1'b1; end
            S_AGITATE:   begin door_lock = 1'b1; motor_on = 1'b1; end
            S_DRAIN:     begin door_lock = 1'b1; drain_valve_on = 1'b1; end
            S_SPIN:      begin door_lock = 1'b1; motor_on = 1'b1; drain_valve_on = 1'b1; end
            S_PAUSED:    begin door_lock = 1'b1; end
            S_DONE:      begin done = 1'b1; end
            S_FAULT:     begin fault = 1'b1; drain_valve_on = 1'b1; door_lock = 1'b1; end
            default:     begin end
        endcase
    end

endmodule
